// File: rtl/logic_operand_loader.sv
// Purpose: capture operands A, B and function F from switches, one per button press, and flag a complete set.
// Latency: capture 2 edges after enter_n is sampled low; with LOGIC_OPERAND_LOADER_DEBOUNCE_EN, DEBOUNCE_CYCLES more.
// Backpressure: none; the operator paces the entry, and each press advances the FSM exactly once.
module logic_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter_n,
    input  logic [3:0] data_in,
    input  logic [1:0] func_in,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic [1:0] f_out,
    output logic       valid,
    output logic [1:0] stage
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_F = 2'd2,
        READY  = 2'd3
    } state_t;

    // The counter must be able to hold DEBOUNCE_CYCLES-1.
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_cfg_check
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       cond_prev_q, cond_prev_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       btn;
    logic       cond;
    logic       press;

    assign btn = ~sync2_q;

`ifdef LOGIC_OPERAND_LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Accept a new button level only after it differs from the stable level for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (btn != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = btn;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign cond = stable_q;
`else
    assign cond = btn;
`endif

    // Synchronizer, edge history and arming. The synchronizer comes out of reset reading "released"
    // for two edges, so a button held through reset would look like a fresh press; arming waits until
    // the pipeline holds real samples and the button has been seen released.
    always_comb begin
        sync1_d     = enter_n;
        sync2_d     = sync1_q;
        cond_prev_d = cond;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & ~cond);
    end

    assign press = cond & ~cond_prev_q & armed_q;

    // Input conditioning registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cond_prev_q <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cond_prev_q <= cond_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] f_q, f_d;
    logic       valid_q, valid_d;

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one step around the ring per press.
    always_comb begin
        state_d = state_q;
        if (press) begin
            case (state_q)
                LOAD_A:  state_d = LOAD_B;
                LOAD_B:  state_d = LOAD_F;
                LOAD_F:  state_d = READY;
                default: state_d = LOAD_A;
            endcase
        end
    end

    // Output values: switches are sampled only on the press that captures them; old operands persist.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        valid_d = (state_d == READY);
        if (press) begin
            case (state_q)
                LOAD_A:  a_d = data_in;
                LOAD_B:  b_d = data_in;
                LOAD_F:  f_d = func_in;
                default: ;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign f_out = f_q;
    assign valid = valid_q;
    assign stage = state_q;

endmodule

// File: tb/tb_logic_operand_loader.sv
// Directed bench for logic_operand_loader with DEBOUNCE_CYCLES=4.
// Expectations follow whichever build is compiled (debounce macro defined or not).
module tb_logic_operand_loader;

`ifdef LOGIC_OPERAND_LOADER_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 7;   // negedges from driving enter_n low to capture visible
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_n;
    logic [3:0] data_in;
    logic [1:0] func_in;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [1:0] f_out;
    logic       valid;
    logic [1:0] stage;

    int n_checks = 0;
    int n_fail   = 0;

    logic_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .enter_n (enter_n),
        .data_in (data_in),
        .func_in (func_in),
        .a_out   (a_out),
        .b_out   (b_out),
        .f_out   (f_out),
        .valid   (valid),
        .stage   (stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int low_n, input int high_n);
        enter_n = 1'b0;
        cycles(low_n);
        enter_n = 1'b1;
        cycles(high_n);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enter_n = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(4);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        enter_n = 1'b0;
        data_in = 4'h0;
        func_in = 2'b00;

        // Reset with the button held down.
        cycles(3);
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_f", f_out, 0);
        check("rst_valid", valid, 0);
        check("rst_stage", stage, 0);

        // Keep holding after reset: no event until release and re-press.
        data_in = 4'hE;
        reset   = 1'b0;
        cycles(20);
        check("held_after_rst_stage", stage, 0);
        enter_n = 1'b1;
        cycles(12);
        check("released_stage", stage, 0);
        press(10, 12);
        check("repress_stage", stage, 1);
        check("repress_a", a_out, 8'hE);

        // Capture latency from the first low sample.
        do_reset();
        data_in = 4'h7;
        enter_n = 1'b0;
        cycles(LAT - 1);
        check("lat_before", stage, 0);
        cycles(1);
        check("lat_stage", stage, 1);
        check("lat_a", a_out, 8'h7);
        enter_n = 1'b1;
        data_in = 4'h0;
        cycles(12);
        check("lat_no_double", stage, 1);

        // Clean entry of A, B, F, with switches changed between presses.
        do_reset();
        data_in = 4'hA;
        press(10, 12);
        data_in = 4'hF;
        check("clean_stage1", stage, 1);
        check("clean_valid1", valid, 0);
        data_in = 4'h5;
        press(10, 12);
        data_in = 4'h0;
        check("clean_stage2", stage, 2);
        func_in = 2'b10;
        press(10, 12);
        func_in = 2'b01;
        check("clean_stage3", stage, 3);
        check("clean_valid", valid, 1);
        check("clean_a", a_out, 8'hA);
        check("clean_b", b_out, 8'h5);
        check("clean_f", f_out, 8'h2);

        // READY wraps to LOAD_A, operands retained until overwritten.
        press(10, 12);
        check("wrap_stage", stage, 0);
        check("wrap_valid", valid, 0);
        check("wrap_a_kept", a_out, 8'hA);
        data_in = 4'h1;
        press(10, 12);
        check("wrap_a_new", a_out, 8'h1);
        check("wrap_b_kept", b_out, 8'h5);
        check("wrap_f_kept", f_out, 8'h2);

        // Bouncing button: low 2, high 1, low 3, high 1, then low.
        do_reset();
        data_in = 4'h8;
        func_in = 2'b01;
        enter_n = 1'b0; cycles(2);
        enter_n = 1'b1; cycles(1);
        enter_n = 1'b0; cycles(3);
        enter_n = 1'b1; cycles(1);
        enter_n = 1'b0;
        cycles(LAT - 1);
        check("bounce_pre", stage, DEB ? 8'd0 : 8'd2);
        cycles(1);
        check("bounce_cap", stage, DEB ? 8'd1 : 8'd3);
        cycles(10 - LAT);
        enter_n = 1'b1;
        cycles(12);
        check("bounce_final", stage, DEB ? 8'd1 : 8'd3);
        check("bounce_a", a_out, 8'h8);

        // Long hold in LOAD_B with switches changing mid-hold.
        do_reset();
        data_in = 4'h2;
        press(10, 12);
        data_in = 4'h9;
        enter_n = 1'b0;
        cycles(20);
        data_in = 4'h6;
        cycles(80);
        enter_n = 1'b1;
        cycles(12);
        check("hold_stage", stage, 2);
        check("hold_b", b_out, 8'h9);
        check("hold_a", a_out, 8'h2);

        // Single-cycle low pulse.
        do_reset();
        data_in = 4'hB;
        press(1, 12);
        check("pulse_stage", stage, DEB ? 8'd0 : 8'd1);
        check("pulse_a", a_out, DEB ? 8'h0 : 8'hB);

        // Reset in LOAD_F after A=3, B=C.
        do_reset();
        data_in = 4'h3;
        press(10, 12);
        data_in = 4'hC;
        press(10, 12);
        check("lf_stage", stage, 2);
        reset = 1'b1;
        cycles(1);
        check("lf_rst_stage", stage, 0);
        check("lf_rst_a", a_out, 0);
        check("lf_rst_b", b_out, 0);
        check("lf_rst_valid", valid, 0);

        // Reset in READY.
        do_reset();
        data_in = 4'h4;
        press(10, 12);
        press(10, 12);
        func_in = 2'b11;
        press(10, 12);
        check("rdy_valid", valid, 1);
        check("rdy_f", f_out, 8'h3);
        reset = 1'b1;
        cycles(1);
        check("rdy_rst_stage", stage, 0);
        check("rdy_rst_valid", valid, 0);
        check("rdy_rst_f", f_out, 0);
        reset = 1'b0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
